// File: rtl/light_grid_engine.sv
// Rectangle light-grid engine: applies on/off/toggle (or brightness) instructions to a
// RAM-backed GRID_SIZE x GRID_SIZE grid, LANES cells per word, then sums the grid.

module light_grid_lane #(
    parameter int MODE = 1,
    parameter int CW   = 8
) (
    input  logic [1:0]    op,
    input  logic          active,
    input  logic [CW-1:0] cell_in,
    output logic [CW-1:0] cell_out
);
    if (MODE == 0) begin : g_bin
        always_comb begin
            cell_out = cell_in;
            if (active) begin
                case (op)
                    2'b00:   cell_out = '0;
                    2'b01:   cell_out = CW'(1);
                    2'b10:   cell_out = ~cell_in;
                    default: cell_out = cell_in;
                endcase
            end
        end
    end else begin : g_bri
        localparam logic [CW-1:0] MAX = '1;
        // Brightness saturates at both ends rather than wrapping.
        always_comb begin
            cell_out = cell_in;
            if (active) begin
                case (op)
                    2'b00:   cell_out = (cell_in == '0) ? '0 : cell_in - CW'(1);
                    2'b01:   cell_out = (cell_in == MAX) ? MAX : cell_in + CW'(1);
                    2'b10:   cell_out = (cell_in >= MAX - CW'(1)) ? MAX : cell_in + CW'(2);
                    default: cell_out = cell_in;
                endcase
            end
        end
    end
endmodule

module light_grid_engine #(
    parameter int COORD_WIDTH       = 12,
    parameter int GRID_SIZE         = 1000,
    parameter int LANES             = 4,
    parameter int MODE              = 1,
    parameter int CELL_WIDTH        = 8,
    parameter int RESULT_WIDTH      = 24,
    parameter int INSTRUCTION_WIDTH = 2 + 4*COORD_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    input  logic [INSTRUCTION_WIDTH-1:0] instr_data,
    input  logic                         instr_last,
    output logic                         busy,
    output logic                         instr_error,
    output logic                         count_done,
    output logic [RESULT_WIDTH-1:0]      count_value
);
    localparam int CW     = (MODE == 0) ? 1 : CELL_WIDTH;
    localparam int WPR    = (GRID_SIZE + LANES - 1) / LANES;
    localparam int DEPTH  = GRID_SIZE * WPR;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW     = $clog2(DEPTH + 2);
    localparam int XW     = COORD_WIDTH + 1;
    localparam int STAGES = 0;

    localparam logic [2:0] S_CLEAR = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_SUM   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]             state;
    logic [1:0]             f_op;
    logic [COORD_WIDTH-1:0] f_x0, f_y0, f_x1, f_y1;
    logic                   f_ok;
    logic [COORD_WIDTH-1:0] w0_n, w1_n;
    logic [AW-1:0]          row0_n;
    logic [XW-1:0]          col0_n;

    logic [1:0]             op_q;
    logic [XW-1:0]          x0_q, x1_q, col_q, col0_q, pipe_col;
    logic [COORD_WIDTH-1:0] y_q, y1_q, w_q, w0_q, w1_q;
    logic [AW-1:0]          cur_addr, row_addr, clr_addr, pipe_addr;
    logic                   last_q;
    logic [SW-1:0]          sum_cnt;
    logic                   sum_vld;
    logic [RESULT_WIDTH-1:0] acc, lane_sum;
    logic [STAGES:0]        vld_pipe;

    logic                   run_rd, sum_rd, rd_en, wr_en;
    logic [AW-1:0]          rd_addr, wr_addr;
    logic [LANES*CW-1:0]    wr_data;
    logic [LANES*CW-1:0]    mem [DEPTH];
    logic [LANES-1:0][CW-1:0] rd_word, mod_word;
    logic [LANES-1:0]       lane_act;

    assign {f_op, f_x0, f_y0, f_x1, f_y1} = instr_data;
    assign f_ok = (f_op != 2'b11) && (f_x0 <= f_x1) && (f_y0 <= f_y1) &&
                  (32'(f_x1) < GRID_SIZE) && (32'(f_y1) < GRID_SIZE);
    assign w0_n   = COORD_WIDTH'(32'(f_x0) / LANES);
    assign w1_n   = COORD_WIDTH'(32'(f_x1) / LANES);
    assign row0_n = AW'(32'(f_y0) * WPR + 32'(f_x0) / LANES);
    assign col0_n = XW'((32'(f_x0) / LANES) * LANES);

    assign instr_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE) && (state != S_DONE);
    assign count_done  = (state == S_DONE);

    assign run_rd  = (state == S_RUN);
    assign sum_rd  = (state == S_SUM) && (sum_cnt < SW'(DEPTH));
    assign rd_en   = run_rd || sum_rd;
    assign rd_addr = (state == S_SUM) ? sum_cnt[AW-1:0] : cur_addr;
    assign wr_en   = (state == S_CLEAR) || vld_pipe[STAGES];
    assign wr_addr = (state == S_CLEAR) ? clr_addr : pipe_addr;
    assign wr_data = (state == S_CLEAR) ? '0 : mod_word;

    // Single-port-per-direction RAM; read data lands one cycle after the request.
    always_ff @(posedge clk) begin
        if (rd_en) rd_word <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [XW-1:0] col;
        assign col         = pipe_col + XW'(i);
        assign lane_act[i] = (col >= x0_q) && (col <= x1_q);
        light_grid_lane #(.MODE(MODE), .CW(CW)) u_lane (
            .op       (op_q),
            .active   (lane_act[i]),
            .cell_in  (rd_word[i]),
            .cell_out (mod_word[i])
        );
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) lane_sum = lane_sum + RESULT_WIDTH'(rd_word[i]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_CLEAR;
            clr_addr    <= '0;
            sum_cnt     <= '0;
            sum_vld     <= 1'b0;
            acc         <= '0;
            vld_pipe    <= '0;
            pipe_addr   <= '0;
            pipe_col    <= '0;
            op_q        <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            y_q         <= '0;
            y1_q        <= '0;
            w_q         <= '0;
            w0_q        <= '0;
            w1_q        <= '0;
            cur_addr    <= '0;
            row_addr    <= '0;
            col_q       <= '0;
            col0_q      <= '0;
            last_q      <= 1'b0;
            instr_error <= 1'b0;
            count_value <= '0;
        end else begin
            vld_pipe  <= (STAGES+1)'({vld_pipe, run_rd});
            pipe_addr <= cur_addr;
            pipe_col  <= col_q;
            sum_vld   <= sum_rd;
            if (state != S_SUM) begin
                sum_cnt <= '0;
                acc     <= '0;
            end
            case (state)
                S_CLEAR: begin
                    clr_addr <= clr_addr + AW'(1);
                    if (clr_addr == AW'(DEPTH - 1)) state <= S_IDLE;
                end
                S_IDLE: begin
                    if (instr_valid) begin
                        if (f_ok) begin
                            op_q     <= f_op;
                            x0_q     <= XW'(f_x0);
                            x1_q     <= XW'(f_x1);
                            y_q      <= f_y0;
                            y1_q     <= f_y1;
                            w_q      <= w0_n;
                            w0_q     <= w0_n;
                            w1_q     <= w1_n;
                            cur_addr <= row0_n;
                            row_addr <= row0_n;
                            col_q    <= col0_n;
                            col0_q   <= col0_n;
                            last_q   <= instr_last;
                            state    <= S_RUN;
                        end else begin
                            instr_error <= 1'b1;
                            if (instr_last) state <= S_SUM;
                        end
                    end
                end
                S_RUN: begin
                    if (w_q == w1_q) begin
                        if (y_q == y1_q) begin
                            state <= S_DRAIN;
                        end else begin
                            y_q      <= y_q + COORD_WIDTH'(1);
                            row_addr <= row_addr + AW'(WPR);
                            cur_addr <= row_addr + AW'(WPR);
                            w_q      <= w0_q;
                            col_q    <= col0_q;
                        end
                    end else begin
                        w_q      <= w_q + COORD_WIDTH'(1);
                        cur_addr <= cur_addr + AW'(1);
                        col_q    <= col_q + XW'(LANES);
                    end
                end
                // Lets the last write-back land before another instruction can read.
                S_DRAIN: state <= last_q ? S_SUM : S_IDLE;
                S_SUM: begin
                    sum_cnt <= sum_cnt + SW'(1);
                    if (sum_vld) acc <= acc + lane_sum;
                    if (sum_cnt == SW'(DEPTH + 1)) begin
                        count_value <= acc;
                        state       <= S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_light_grid_engine.sv
// Scoreboard bench: a brightness engine and a binary engine share one instruction stream
// and are compared against a plain-array grid model.

module tb_light_grid_engine;
    localparam int CWD   = 4;
    localparam int G     = 10;
    localparam int L     = 4;
    localparam int WPR   = (G + L - 1) / L;
    localparam int DEPTH = G * WPR;
    localparam int IW    = 2 + 4*CWD;
    localparam int MAXB  = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic instr_valid = 1'b0;
    logic [IW-1:0] instr_data = '0;
    logic instr_last = 1'b0;
    logic ready_b, busy_b, err_b, done_b;
    logic ready_p, busy_p, err_p, done_p;
    logic [23:0] value_b, value_p;

    light_grid_engine #(.COORD_WIDTH(CWD), .GRID_SIZE(G), .LANES(L), .MODE(1),
                        .CELL_WIDTH(2), .RESULT_WIDTH(24)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(ready_b),
        .instr_data(instr_data), .instr_last(instr_last), .busy(busy_b),
        .instr_error(err_b), .count_done(done_b), .count_value(value_b));

    light_grid_engine #(.COORD_WIDTH(CWD), .GRID_SIZE(G), .LANES(L), .MODE(0),
                        .CELL_WIDTH(2), .RESULT_WIDTH(24)) u_dut_p (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(ready_p),
        .instr_data(instr_data), .instr_last(instr_last), .busy(busy_p),
        .instr_error(err_p), .count_done(done_p), .count_value(value_p));

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int     exp_b;
        int     exp_p;
        bit     exp_err;
        longint exp_cyc;
    } exp_t;
    exp_t sb[$];

    int bri [G][G];
    bit onp [G][G];
    bit m_err;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int y = 0; y < G; y++)
            for (int x = 0; x < G; x++) begin
                bri[y][x] = 0;
                onp[y][x] = 1'b0;
            end
        m_err = 1'b0;
    endtask

    task automatic model_apply(input int op, x0, y0, x1, y1, output bit ok, output int runs);
        ok   = (op != 3) && (x0 <= x1) && (y0 <= y1) && (x1 < G) && (y1 < G);
        runs = 0;
        if (!ok) begin
            m_err = 1'b1;
            return;
        end
        runs = (y1 - y0 + 1) * (x1 / L - x0 / L + 1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) begin
                case (op)
                    0: begin bri[y][x] = (bri[y][x] > 0) ? bri[y][x] - 1 : 0; onp[y][x] = 1'b0; end
                    1: begin bri[y][x] = (bri[y][x] + 1 > MAXB) ? MAXB : bri[y][x] + 1; onp[y][x] = 1'b1; end
                    default: begin bri[y][x] = (bri[y][x] + 2 > MAXB) ? MAXB : bri[y][x] + 2; onp[y][x] = !onp[y][x]; end
                endcase
            end
    endtask

    function automatic int sum_b();
        int s = 0;
        for (int y = 0; y < G; y++) for (int x = 0; x < G; x++) s += bri[y][x];
        return s;
    endfunction

    function automatic int sum_p();
        int s = 0;
        for (int y = 0; y < G; y++) for (int x = 0; x < G; x++) s += int'(onp[y][x]);
        return s;
    endfunction

    // Monitor: pops one expectation per rising count_done.
    initial begin : monitor
        bit seen = 1'b0;
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (done_b && !seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("value_bright", value_b, e.exp_b);
                    chk("value_binary", value_p, e.exp_p);
                    chk("error_bright", err_b, e.exp_err);
                    chk("error_binary", err_p, e.exp_err);
                    chk("done_binary", done_p, 1);
                    chk("done_cycle", cyc, e.exp_cyc);
                end
            end
            if (!done_b) seen = 1'b0;
        end
    end

    task automatic do_reset();
        int n = 0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("rst_ready", {ready_b, ready_p}, 0);
        chk("rst_busy", {busy_b, busy_p}, 3);
        chk("rst_error", {err_b, err_p}, 0);
        chk("rst_done", {done_b, done_p}, 0);
        chk("rst_value", value_b + value_p, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        while (!ready_b && n < 200) begin @(posedge clk); #1; n++; end
        chk("clear_len", n, DEPTH);
        model_clear();
    endtask

    task automatic issue(input int op, x0, y0, x1, y1, input bit last, output longint k);
        int n = 0;
        instr_valid = 1'b1;
        instr_data  = {2'(op), 4'(x0), 4'(y0), 4'(x1), 4'(y1)};
        instr_last  = last;
        while (!ready_b && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) chk("accept_timeout", n, 0);
        @(posedge clk); #1;
        k           = cyc;
        instr_valid = 1'b0;
        instr_last  = 1'($urandom_range(0, 1));
        instr_data  = IW'($urandom);
    endtask

    task automatic wait_sb();
        int n = 0;
        while (sb.size() > 0 && n < 500) begin @(posedge clk); #1; n++; end
        if (sb.size() > 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic send(input int op, x0, y0, x1, y1, input bit last);
        bit ok;
        int r;
        int n = 0;
        longint k;
        exp_t e;
        model_apply(op, x0, y0, x1, y1, ok, r);
        issue(op, x0, y0, x1, y1, last, k);
        if (last) begin
            e.exp_b   = sum_b();
            e.exp_p   = sum_p();
            e.exp_err = m_err;
            e.exp_cyc = ok ? k + r + DEPTH + 3 : k + DEPTH + 2;
            sb.push_back(e);
            wait_sb();
        end else begin
            while (!ready_b && n < 200) begin @(posedge clk); #1; n++; end
            chk("occupancy", n, ok ? r + 1 : 0);
        end
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin : driver
        longint k;
        int nb;
        int a, b, c, d;
        // Reserved op as the only, final instruction.
        do_reset();
        send(3, 0, 0, 0, 0, 1);
        // Saturation at both ends.
        do_reset();
        send(2, 3, 3, 3, 3, 0);
        send(2, 3, 3, 3, 3, 0);
        send(0, 5, 5, 5, 5, 0);
        send(1, 3, 3, 3, 3, 1);
        // Lane masking across two words.
        do_reset();
        send(1, 1, 2, 6, 2, 1);
        // Whole grid including padding lanes, then a row toggle.
        do_reset();
        send(1, 0, 0, 9, 9, 0);
        send(2, 0, 0, 9, 0, 1);
        // Dropped geometry, ending with a dropped last.
        do_reset();
        send(1, 5, 0, 4, 0, 0);
        send(1, 0, 10, 0, 10, 0);
        send(1, 0, 0, 0, 0, 0);
        send(0, 0, 0, 10, 0, 1);
        // Reset in the middle of a long instruction.
        do_reset();
        send(3, 1, 1, 1, 1, 0);
        issue(2, 0, 0, 9, 9, 0, k);
        repeat (5) @(posedge clk);
        #1;
        chk("midrun_busy", busy_b, 1);
        chk("midrun_error", err_b, 1);
        do_reset();
        send(1, 0, 0, 9, 0, 1);
        // Randomised batches.
        for (int t = 0; t < 14; t++) begin
            do_reset();
            nb = $urandom_range(1, 6);
            for (int i = 0; i < nb; i++) begin
                a = $urandom_range(0, 11);
                b = $urandom_range(0, 11);
                c = $urandom_range(0, 11);
                d = $urandom_range(0, 11);
                if ($urandom_range(0, 4) != 0) begin
                    if (a > b) begin int s = a; a = b; b = s; end
                    if (c > d) begin int s = c; c = d; d = s; end
                end
                send($urandom_range(0, 3), a, c, b, d, i == nb - 1);
            end
        end
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
